// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: occupancy states,
// control-bundle bit positions and the bubble encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  localparam int CTRL_W_DEF = 9;

  // Control bundle layout, shared with the control unit and stage logic
  localparam int CTRL_ALOP_LO  = 0;
  localparam int CTRL_ALOP_HI  = 1;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMREG   = 5;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_BRANCH   = 7;
  localparam int CTRL_REGDST   = 8;

  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

  // True when a control word would change architectural state
  function automatic logic ctrl_has_side_effect(input logic [CTRL_W_DEF-1:0] c);
    return c[CTRL_REGWRITE] | c[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline buffer with valid/ready handshake, flush,
// bubble insertion and an optional two-entry skid for a registered in_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level
);

  buf_state_t        state;
  buf_state_t        state_nxt;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] head_data_nxt;
  logic [CTRL_W-1:0] head_ctrl;
  logic [CTRL_W-1:0] head_ctrl_nxt;
  logic              accept;
  logic              consume;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign consume   = out_valid & out_ready;

  // Head register: the entry presented downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head_data <= '0;
      head_ctrl <= '0;
    end else begin
      state     <= state_nxt;
      head_data <= head_data_nxt;
      head_ctrl <= head_ctrl_nxt;
    end
  end

  assign out_data = head_data;
  assign out_ctrl = out_valid ? head_ctrl : CTRL_W'(CTRL_BUBBLE);
  assign level    = 2'(state);

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              ld_skid;
    logic              in_ready_r;

    always_comb begin
      state_nxt     = state;
      head_data_nxt = head_data;
      head_ctrl_nxt = head_ctrl;
      ld_skid       = 1'b0;
      if (flush) begin
        state_nxt = EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state_nxt     = ONE;
              head_data_nxt = in_data;
              head_ctrl_nxt = in_ctrl;
            end
          end
          ONE: begin
            if (accept && consume) begin
              head_data_nxt = in_data;
              head_ctrl_nxt = in_ctrl;
            end else if (accept) begin
              state_nxt = TWO;
              ld_skid   = 1'b1;
            end else if (consume) begin
              state_nxt = EMPTY;
            end
          end
          TWO: begin
            // in_ready is low here, so only a consume can move us
            if (consume) begin
              state_nxt     = ONE;
              head_data_nxt = skid_data;
              head_ctrl_nxt = skid_ctrl;
            end
          end
          default: state_nxt = EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        skid_data  <= '0;
        skid_ctrl  <= '0;
        in_ready_r <= 1'b0;
      end else begin
        if (ld_skid) begin
          skid_data <= in_data;
          skid_ctrl <= in_ctrl;
        end
        in_ready_r <= (state_nxt != TWO);
      end
    end

    assign in_ready = in_ready_r;
  end else begin : g_noskid
    always_comb begin
      state_nxt     = state;
      head_data_nxt = head_data;
      head_ctrl_nxt = head_ctrl;
      if (flush) begin
        state_nxt = EMPTY;
      end else if (accept) begin
        state_nxt     = ONE;
        head_data_nxt = in_data;
        head_ctrl_nxt = in_ctrl;
      end else if (consume) begin
        state_nxt = EMPTY;
      end
    end

    // Ready passes straight through from downstream; no second slot exists
    assign in_ready = ~rst & (~out_valid | out_ready);
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench driving a SKID=0 and a SKID=1 buffer from the same stimulus.
module tb_pipe_stage_buf;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 9;
  localparam int EW     = DATA_W + CTRL_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;

  logic              in_rdy [2];
  logic              ov     [2];
  logic [DATA_W-1:0] od     [2];
  logic [CTRL_W-1:0] oc     [2];
  logic [1:0]        lvl    [2];

  logic [EW-1:0] q [2][$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  logic rst_prev = 1'b1;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_ctrl(oc[0]), .level(lvl[0]));

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_ctrl(oc[1]), .level(lvl[1]));

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s skid=%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Monitor + reference model: a buffer is a bounded FIFO cleared by flush/rst
  int            sz;
  logic          exp_rdy;
  logic          acc;
  logic          con;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        sz  = q[k].size();
        acc = in_valid & in_rdy[k];
        con = ov[k] & out_ready;
        chk("level", k, 64'(lvl[k]), 64'(sz));
        chk("out_valid", k, 64'(ov[k]), 64'(sz != 0));
        if (!ov[k]) chk("bubble_ctrl", k, 64'(oc[k]), 64'd0);
        if (k == 1) exp_rdy = !rst_prev && (sz < 2);
        else        exp_rdy = !rst && ((sz == 0) || out_ready);
        chk("in_ready", k, 64'(in_rdy[k]), 64'(exp_rdy));
        if (con && sz > 0) begin
          e = q[k].pop_front();
          chk("out_data", k, 64'(od[k]), 64'(e[EW-1:CTRL_W]));
          chk("out_ctrl", k, 64'(oc[k]), 64'(e[CTRL_W-1:0]));
        end
        if (rst) begin
          q[k].delete();
        end else begin
          if (acc) q[k].push_back({in_data, in_ctrl});
          if (flush) q[k].delete();
        end
      end
      rst_prev = rst;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                     input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) chk("reset_data", k, 64'(od[k]), 64'd0);

    // Stream 4..0x10 with downstream always ready
    for (int i = 1; i <= 4; i++) drv(1'b1, DATA_W'(4 * i), 9'h044, 1'b1, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall: head 0xA, downstream stalls 3 cycles while 0xB/0xC are offered
    drv(1'b1, 32'hA, 9'h00A, 1'b1, 1'b0);
    drv(1'b1, 32'hB, 9'h00B, 1'b0, 1'b0);
    drv(1'b1, 32'hC, 9'h00C, 1'b0, 1'b0);
    drv(1'b1, 32'hC, 9'h00C, 1'b0, 1'b0);
    drv(1'b1, 32'hC, 9'h00C, 1'b1, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drv(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with two held entries and a simultaneous offer of 0x33
    drv(1'b1, 32'h11, 9'h011, 1'b0, 1'b0);
    drv(1'b1, 32'h22, 9'h022, 1'b0, 1'b0);
    drv(1'b1, 32'h33, 9'h033, 1'b0, 1'b1);
    drv(1'b0, '0, '0, 1'b1, 1'b0);

    // Bubble: control bus all ones while invalid
    drv(1'b0, 32'hDEAD, 9'h1FF, 1'b1, 1'b0);
    drv(1'b0, 32'hBEEF, 9'h1FF, 1'b1, 1'b0);

    // Reset mid-operation with two held entries
    drv(1'b1, 32'h44, 9'h044, 1'b0, 1'b0);
    drv(1'b1, 32'h55, 9'h055, 1'b0, 1'b0);
    rst = 1'b1;
    drv(1'b1, 32'h66, 9'h066, 1'b0, 1'b0);
    rst = 1'b0;
    drv(1'b0, '0, '0, 1'b0, 1'b0);

    // Head 0x5 stalled, then consume and replace with 0x6 in one cycle
    drv(1'b1, 32'h5, 9'h105, 1'b0, 1'b0);
    drv(1'b0, '0, '0, 1'b0, 1'b0);
    drv(1'b1, 32'h6, 9'h106, 1'b1, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      in_data   = $urandom;
      in_ctrl   = CTRL_W'($urandom_range(0, 511));
      cyc();
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drv(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("drained", k, 64'(q[k].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
